// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation core: FSM state
// encoding and the modular multiplier's fixed latency.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        SQR   = 3'd2,
        MUL   = 3'd3,
        FIN   = 3'd4
    } rsa_state_t;

    // Cycles per modular product: one issue cycle, one per operand bit, one capture.
    function automatic int mul_latency(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/rsa_modmul.sv
// MSB-first interleaved shift-add-subtract modular multiplier: p = a*b mod n,
// with a, b < n, in exactly mul_latency(WIDTH) cycles from the go cycle.
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int LAT = mul_latency(WIDTH);
    localparam int CW  = $clog2(LAT);
    localparam logic [CW-1:0] CAP_CYC = CW'(LAT - 1);

    logic [CW-1:0]    cyc;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH+1:0] n_ext;
    logic [WIDTH+1:0] dbl;
    logic [WIDTH+1:0] red1;
    logic [WIDTH+1:0] sum;
    logic [WIDTH-1:0] next_p;

    // Each step doubles, reduces, conditionally adds a, reduces again, so the
    // running value stays below n and every sum fits in WIDTH+2 bits.
    always_comb begin
        n_ext  = {2'b00, n_q};
        dbl    = {1'b0, p, 1'b0};
        red1   = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
        sum    = red1 + (b_q[WIDTH-1] ? {2'b00, a_q} : '0);
        next_p = WIDTH'((sum >= n_ext) ? (sum - n_ext) : sum);
    end

    assign busy = (cyc != '0);
    assign done = (cyc == CAP_CYC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc <= '0;
            a_q <= '0;
            b_q <= '0;
            n_q <= '0;
            p   <= '0;
        end else if (cyc == '0) begin
            if (go) begin
                a_q <= a;
                b_q <= b;
                n_q <= n;
                p   <= '0;
                cyc <= CW'(1);
            end
        end else if (cyc == CAP_CYC) begin
            cyc <= '0;
        end else begin
            p   <= next_p;
            b_q <= {b_q[WIDTH-2:0], 1'b0};
            cyc <= cyc + CW'(1);
        end
    end

endmodule

// File: rtl/rsa_modexp_core.sv
// Constant-time left-to-right square-and-multiply modular exponentiation:
// result = message^(mode ? d : e) mod n, with operand checking.
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] message,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] d,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output rsa_state_t       fsm_state
);

    localparam int IW = $clog2(WIDTH);

    // Handshake: start is taken on a rising edge only while busy=0; busy is high
    // from the next cycle until the edge that raises the one-cycle done pulse.
    rsa_state_t       state;
    rsa_state_t       state_next;
    logic [WIDTH-1:0] msg_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] acc;
    logic [IW-1:0]    idx;
    logic             chk_err;
    logic             operands_bad;
    logic             mm_go;
    logic             mm_busy;
    logic             mm_done;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_p;

    assign operands_bad = (n_q < WIDTH'(2)) || (msg_q >= n_q);
    assign fsm_state    = state;

    always_comb begin
        state_next = state;
        mm_go      = 1'b0;
        mm_b       = acc;
        case (state)
            IDLE:  if (start) state_next = CHECK;
            CHECK: state_next = operands_bad ? FIN : SQR;
            SQR: begin
                mm_go = !mm_busy;
                if (mm_done) state_next = MUL;
            end
            MUL: begin
                // Product is always formed so timing never depends on the exponent.
                mm_b  = msg_q;
                mm_go = !mm_busy;
                if (mm_done) state_next = (idx == '0) ? FIN : SQR;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg_q   <= '0;
            n_q     <= '0;
            exp_q   <= '0;
            acc     <= '0;
            idx     <= '0;
            chk_err <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        msg_q <= message;
                        n_q   <= n;
                        exp_q <= mode ? d : e;
                        busy  <= 1'b1;
                    end
                end
                CHECK: begin
                    chk_err <= operands_bad;
                    acc     <= operands_bad ? '0 : WIDTH'(1);
                    idx     <= IW'(WIDTH - 1);
                end
                SQR: if (mm_done) acc <= mm_p;
                MUL: begin
                    if (mm_done) begin
                        if (exp_q[idx]) acc <= mm_p;
                        idx <= idx - IW'(1);
                    end
                end
                FIN: begin
                    result <= acc;
                    err    <= chk_err;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
        .clk  (clk),
        .rst  (rst),
        .go   (mm_go),
        .a    (acc),
        .b    (mm_b),
        .n    (n_q),
        .busy (mm_busy),
        .done (mm_done),
        .p    (mm_p)
    );

endmodule
